// File: rtl/pgm_ddram_responder.sv
// Responder for the PGM core's ddram_* request bus: posted-write FIFO plus single-beat Avalon-MM reads.
// Optional one-line read cache is built when PGM_DDR_RDCACHE_EN is defined.
module pgm_ddram_responder #(
  parameter int WFIFO_DEPTH = 4,
  parameter int ADDR_W      = 29
) (
  input  logic              fixed_50m_clk,
  input  logic              reset,
  input  logic              ddram_rd,
  input  logic              ddram_we,
  input  logic [ADDR_W-1:0] ddram_addr,
  input  logic [63:0]       ddram_din,
  input  logic [7:0]        ddram_be,
  output logic [63:0]       ddram_dout,
  output logic              ddram_dout_ready,
  output logic              ddram_busy,
  output logic              wr_overflow,
  output logic              avl_rd,
  output logic              avl_we,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [7:0]        avl_burstcnt,
  output logic [63:0]       avl_din,
  output logic [7:0]        avl_be,
  input  logic              avl_busy,
  input  logic [63:0]       avl_dout,
  input  logic              avl_dout_ready
);
  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RESP, COOL} state_t;
  state_t state_reg, state_next;

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [63:0]       fifo_din  [WFIFO_DEPTH];
  logic [7:0]        fifo_be   [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [63:0]       dout_reg;
  logic              overflow_reg;
  logic              push, pop, accept_rd, rsp_fill, cache_hit;
  logic [63:0]       cache_data;

  assign ddram_busy   = (count_reg == CNT_W'(WFIFO_DEPTH));
  assign push         = ddram_we && !ddram_busy;
  assign pop          = (state_reg == WR) && !avl_busy;
  assign rsp_fill     = (state_reg == RD_WAIT) && avl_dout_ready;
  assign ddram_dout   = dout_reg;
  assign wr_overflow  = overflow_reg;
  assign avl_burstcnt = 8'd1;

  always_ff @(posedge fixed_50m_clk) begin
    if (push) begin
      fifo_addr[wr_ptr_reg] <= ddram_addr;
      fifo_din[wr_ptr_reg]  <= ddram_din;
      fifo_be[wr_ptr_reg]   <= ddram_be;
    end
  end

  always_ff @(posedge fixed_50m_clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_addr_reg  <= '0;
      dout_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (ddram_we && ddram_busy) overflow_reg <= 1'b1;
      if (accept_rd) rd_addr_reg <= ddram_addr;
      if (rsp_fill) dout_reg <= avl_dout;
      else if (accept_rd && cache_hit) dout_reg <= cache_data;
    end
  end

`ifdef PGM_DDR_RDCACHE_EN
  logic              cache_valid_reg;
  logic [ADDR_W-1:0] cache_tag_reg;
  logic [63:0]       cache_data_reg;
  logic [ADDR_W-1:0] tag_after_fill;

  // A write pushed in the same cycle as a fill must still invalidate the new line.
  assign tag_after_fill = rsp_fill ? rd_addr_reg : cache_tag_reg;

  always_ff @(posedge fixed_50m_clk) begin
    if (reset) begin
      cache_valid_reg <= 1'b0;
      cache_tag_reg   <= '0;
      cache_data_reg  <= '0;
    end else begin
      if (rsp_fill) begin
        cache_valid_reg <= 1'b1;
        cache_tag_reg   <= rd_addr_reg;
        cache_data_reg  <= avl_dout;
      end
      if (push && (ddram_addr == tag_after_fill)) cache_valid_reg <= 1'b0;
    end
  end

  assign cache_hit  = cache_valid_reg && (cache_tag_reg == ddram_addr);
  assign cache_data = cache_data_reg;
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_comb begin
    state_next       = state_reg;
    accept_rd        = 1'b0;
    avl_rd           = 1'b0;
    avl_we           = 1'b0;
    avl_addr         = '0;
    avl_din          = '0;
    avl_be           = 8'hFF;
    ddram_dout_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        // A write landing this cycle is older than the read, so the read waits.
        if (count_reg != '0) begin
          state_next = WR;
        end else if (!push && ddram_rd) begin
          accept_rd  = 1'b1;
          state_next = cache_hit ? RESP : RD_ISSUE;
        end
      end
      WR: begin
        avl_we   = 1'b1;
        avl_addr = fifo_addr[rd_ptr_reg];
        avl_din  = fifo_din[rd_ptr_reg];
        avl_be   = fifo_be[rd_ptr_reg];
        if (!avl_busy) state_next = IDLE;
      end
      RD_ISSUE: begin
        avl_rd   = 1'b1;
        avl_addr = rd_addr_reg;
        if (!avl_busy) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (avl_dout_ready) state_next = RESP;
      end
      RESP: begin
        ddram_dout_ready = 1'b1;
        state_next       = COOL;
      end
      COOL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pgm_ddram_responder.sv
// Directed bench for pgm_ddram_responder with an Avalon memory model and read/write scoreboards.
module tb_pgm_ddram_responder;
  localparam int AW = 29;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, ddram_rd, ddram_we;
  logic [AW-1:0] ddram_addr;
  logic [63:0]   ddram_din;
  logic [7:0]    ddram_be;
  logic [63:0]   ddram_dout;
  logic          ddram_dout_ready, ddram_busy, wr_overflow;
  logic          avl_rd, avl_we;
  logic [AW-1:0] avl_addr;
  logic [7:0]    avl_burstcnt, avl_be;
  logic [63:0]   avl_din;
  logic          avl_busy;
  logic [63:0]   avl_dout;
  logic          avl_dout_ready;

  pgm_ddram_responder #(.WFIFO_DEPTH(4), .ADDR_W(AW)) dut (
    .fixed_50m_clk(clk), .reset(reset),
    .ddram_rd(ddram_rd), .ddram_we(ddram_we), .ddram_addr(ddram_addr),
    .ddram_din(ddram_din), .ddram_be(ddram_be),
    .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
    .ddram_busy(ddram_busy), .wr_overflow(wr_overflow),
    .avl_rd(avl_rd), .avl_we(avl_we), .avl_addr(avl_addr),
    .avl_burstcnt(avl_burstcnt), .avl_din(avl_din), .avl_be(avl_be),
    .avl_busy(avl_busy), .avl_dout(avl_dout), .avl_dout_ready(avl_dout_ready)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [63:0]   d;
    logic [7:0]    be;
  } wr_t;

  wr_t         wq[$];
  logic [63:0] rd_q[$];
  logic [63:0] mem[logic [AW-1:0]];
  logic [63:0] shadow[logic [AW-1:0]];

  int n_vec = 0, n_err = 0, cyc = 0;
  int rd_acc = 0, wr_acc = 0, resp_cnt = 0;
  int resp_cyc = -1, dr_cyc = -1, rd_first_cyc = -1, wr_acc_cyc = -1;
  logic hold_busy = 1'b0;
  int stall_cnt = 0, rd_lat = 2;
  logic pend_valid = 1'b0;
  int pend_wait = 0;
  logic [63:0] pend_data = '0;

  function automatic logic [63:0] dflt(input logic [AW-1:0] a);
    return 64'hDEAD_0000_0000_0000 | {35'd0, a};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mem_get(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [63:0] shadow_get(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : dflt(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_t w;
    w.a = a; w.d = d; w.be = be;
    wq.push_back(w);
    shadow[a] = merge(shadow_get(a), d, be);
  endtask

  // One clock: observe responses, then play the Avalon slave for the coming edge.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    cyc++;
    if (ddram_dout_ready) begin
      resp_cnt++;
      resp_cyc = cyc;
      check("resp_expected", 64'(rd_q.size() != 0), 64'd1);
      if (rd_q.size() != 0) check("rd_data", ddram_dout, rd_q.pop_front());
    end
    avl_dout_ready = 1'b0;
    if (pend_valid) begin
      if (pend_wait == 0) begin
        avl_dout_ready = 1'b1;
        avl_dout       = pend_data;
        pend_valid     = 1'b0;
        dr_cyc         = cyc;
      end else begin
        pend_wait--;
      end
    end
    avl_busy = hold_busy || (stall_cnt > 0);
    if (stall_cnt > 0) stall_cnt--;
    if (avl_rd && avl_we) check("rd_we_exclusive", 64'(avl_rd & avl_we), 64'd0);
    if (avl_rd && rd_first_cyc < 0) rd_first_cyc = cyc;
    if (avl_rd && !avl_busy) begin
      rd_acc++;
      pend_valid = 1'b1;
      pend_wait  = rd_lat;
      pend_data  = mem_get(avl_addr);
    end
    if (avl_we && !avl_busy) begin
      wr_acc++;
      wr_acc_cyc = cyc;
      check("wr_expected", 64'(wq.size() != 0), 64'd1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        check("wr_addr", 64'(avl_addr), 64'(w.a));
        check("wr_data", avl_din, w.d);
        check("wr_be", 64'(avl_be), 64'(w.be));
      end
      mem[avl_addr] = merge(mem_get(avl_addr), avl_din, avl_be);
    end
  endtask

  task automatic wait_resp(input int r0, input string tag);
    for (int i = 0; i < 200 && resp_cnt == r0; i++) tick();
    check(tag, 64'(resp_cnt != r0), 64'd1);
    if (resp_cnt == r0) rd_q.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && wq.size() != 0; i++) tick();
    check(tag, 64'(wq.size()), 64'd0);
  endtask

  // Requester holds rd until the pulse and drops it one cycle later.
  task automatic do_read(input logic [AW-1:0] a, output int start);
    int r0;
    rd_q.push_back(shadow_get(a));
    ddram_rd   = 1'b1;
    ddram_addr = a;
    start      = cyc;
    r0         = resp_cnt;
    wait_resp(r0, "rd_complete");
    tick();
    tick();
    ddram_rd = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
    ddram_we   = 1'b1;
    ddram_addr = a;
    ddram_din  = d;
    ddram_be   = be;
    expect_wr(a, d, be);
    tick();
    ddram_we = 1'b0;
  endtask

  task automatic check_reset_outs(input string t);
    check({t, "_dout"}, ddram_dout, 64'd0);
    check({t, "_dout_ready"}, 64'(ddram_dout_ready), 64'd0);
    check({t, "_busy"}, 64'(ddram_busy), 64'd0);
    check({t, "_overflow"}, 64'(wr_overflow), 64'd0);
    check({t, "_avl_rd"}, 64'(avl_rd), 64'd0);
    check({t, "_avl_we"}, 64'(avl_we), 64'd0);
    check({t, "_avl_addr"}, 64'(avl_addr), 64'd0);
    check({t, "_avl_burstcnt"}, 64'(avl_burstcnt), 64'd1);
    check({t, "_avl_din"}, avl_din, 64'd0);
    check({t, "_avl_be"}, 64'(avl_be), 64'hFF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, a0, w0, r0, cnt;
    reset = 1'b1; ddram_rd = 1'b0; ddram_we = 1'b0; ddram_addr = '0;
    ddram_din = '0; ddram_be = '0; avl_busy = 1'b0; avl_dout = '0; avl_dout_ready = 1'b0;
    mem[29'h100]    = 64'h1122_3344_5566_7788;
    shadow[29'h100] = 64'h1122_3344_5566_7788;
    repeat (3) tick();
    check_reset_outs("por");
    reset = 1'b0;
    tick();

    // Read miss with three-cycle Avalon latency.
    rd_first_cyc = -1;
    a0 = rd_acc;
    do_read(29'h100, st);
    check("miss_first_avl_rd_cycle", 64'(rd_first_cyc), 64'(st + 1));
    check("miss_resp_after_dout_ready", 64'(resp_cyc), 64'(dr_cyc + 1));
    check("miss_one_avl_rd", 64'(rd_acc - a0), 64'd1);
    repeat (4) tick();
    check("cool_no_reissue", 64'(rd_acc - a0), 64'd1);
    check("dout_held", ddram_dout, 64'h1122_3344_5566_7788);

    // Six back-to-back writes into a four-entry FIFO with Avalon stalled.
    hold_busy = 1'b1;
    tick();
    w0 = wr_acc;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      check("burst_busy", 64'(ddram_busy), 64'(cnt == 4));
      check("burst_overflow", 64'(wr_overflow), 64'(i > 4));
      ddram_we   = 1'b1;
      ddram_addr = 29'h1000 + AW'(i);
      ddram_din  = 64'hBEEF_0000_0000_0000 | (64'(i) * 64'h0101_0101);
      ddram_be   = 8'hFF ^ 8'(i);
      if (cnt < 4) begin
        expect_wr(ddram_addr, ddram_din, ddram_be);
        cnt++;
      end
      tick();
    end
    ddram_we = 1'b0;
    check("burst_busy_full", 64'(ddram_busy), 64'd1);
    check("burst_overflow_set", 64'(wr_overflow), 64'd1);
    check("burst_no_we_while_stalled", 64'(wr_acc - w0), 64'd0);
    hold_busy = 1'b0;
    drain("burst_drain");
    check("burst_four_beats", 64'(wr_acc - w0), 64'd4);
    tick();
    check("burst_busy_clear", 64'(ddram_busy), 64'd0);
    check("burst_overflow_sticky", 64'(wr_overflow), 64'd1);

    // Write and read of the same address raised together: write must go first.
    w0 = wr_acc;
    rd_first_cyc = -1;
    ddram_we   = 1'b1;
    ddram_rd   = 1'b1;
    ddram_addr = 29'h200;
    ddram_din  = 64'hA5A5_0200_5A5A_0200;
    ddram_be   = 8'hFF;
    expect_wr(29'h200, 64'hA5A5_0200_5A5A_0200, 8'hFF);
    rd_q.push_back(shadow_get(29'h200));
    r0 = resp_cnt;
    tick();
    ddram_we = 1'b0;
    wait_resp(r0, "ord_complete");
    check("ord_wr_done", 64'(wr_acc - w0), 64'd1);
    check("ord_rd_after_wr", 64'(rd_first_cyc > wr_acc_cyc), 64'd1);
    tick();
    tick();
    ddram_rd = 1'b0;

    // Avalon stall for ten cycles during RD_ISSUE; requester address wanders meanwhile.
    a0 = rd_acc;
    rd_q.push_back(shadow_get(29'h0ABCDE));
    ddram_rd   = 1'b1;
    ddram_addr = 29'h0ABCDE;
    stall_cnt  = 10;
    r0 = resp_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      ddram_addr = 29'h1FFF_FFFF;
      check("stall_avl_rd", 64'(avl_rd), 64'd1);
      check("stall_avl_addr", 64'(avl_addr), 64'h0ABCDE);
      check("stall_not_accepted", 64'(rd_acc - a0), 64'd0);
    end
    tick();
    check("stall_accept_first_free", 64'(rd_acc - a0), 64'd1);
    wait_resp(r0, "stall_complete");
    tick();
    tick();
    ddram_rd = 1'b0;
    check("stall_one_avl_rd", 64'(rd_acc - a0), 64'd1);

    // Repeat read of one address, then invalidate with a partial write.
    a0 = rd_acc;
    do_read(29'h300, st);
    check("c1_avl_rd", 64'(rd_acc - a0), 64'd1);
    do_read(29'h300, st);
`ifdef PGM_DDR_RDCACHE_EN
    check("c2_hit_no_avl_rd", 64'(rd_acc - a0), 64'd1);
    check("c2_hit_latency", 64'(resp_cyc - st), 64'd1);
`else
    check("c2_miss_avl_rd", 64'(rd_acc - a0), 64'd2);
`endif
    do_write(29'h300, 64'h0000_0000_CAFE_F00D, 8'h0F);
    drain("c3_drain");
    do_read(29'h300, st);
`ifdef PGM_DDR_RDCACHE_EN
    check("c3_avl_rd_after_wr", 64'(rd_acc - a0), 64'd2);
`else
    check("c3_avl_rd_after_wr", 64'(rd_acc - a0), 64'd3);
`endif

    // Reset while waiting for read data; the stale response arrives afterwards.
    rd_lat = 6;
    a0 = rd_acc;
    rd_q.push_back(shadow_get(29'h400));
    ddram_rd   = 1'b1;
    ddram_addr = 29'h400;
    for (int i = 0; i < 50 && rd_acc == a0; i++) tick();
    check("rst_read_accepted", 64'(rd_acc - a0), 64'd1);
    tick();
    r0 = resp_cnt;
    rd_q.delete();
    reset    = 1'b1;
    ddram_rd = 1'b0;
    tick();
    check_reset_outs("mid");
    reset = 1'b0;
    repeat (10) tick();
    check("rst_no_resp", 64'(resp_cnt - r0), 64'd0);
    rd_lat = 2;
    w0 = wr_acc;
    rd_first_cyc = -1;
    do_read(29'h100, st);
    check("rst_fifo_empty_rd_first", 64'(rd_first_cyc), 64'(st + 1));
    check("rst_no_stale_writes", 64'(wr_acc - w0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
